music_player: RTL and testbench
===============================

MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameter ADDR_W, 17, width of the sample-ROM address.
REQ-002 Parameter DATA_W, 17, width of one ROM sample word.
REQ-003 Parameter LAST_ADDR, 43113, highest valid ROM address (last sample).
REQ-004 Parameter DIV, 1250, Clk cycles per sample period (50 MHz / 40 kHz); legal range 4..65535.
REQ-005 Clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 play  in  1  level; 1 = run, 0 = pause, holding position.
REQ-008 restart  in  1  single-cycle pulse; rewind to address 0.
REQ-009 Add  out  ADDR_W  registered address driven to the sample ROM.
REQ-010 music_content  in  DATA_W  ROM data; valid exactly one Clk after Add is presented.
REQ-011 sample_out  out  DATA_W  captured sample toward the audio output stage.
REQ-012 sample_valid  out  1  sample_out holds an unconsumed sample.
REQ-013 sample_ready  in  1  downstream accepts sample_out this cycle.
REQ-014 playing  out  1  high in every state except IDLE.
REQ-015 overrun  out  1  sticky; a sample tick arrived while a sample was still pending.

Function
REQ-016 Divider div_cnt counts 0..DIV-1 while play=1; tick is asserted in the cycle div_cnt==DIV-1, and div_cnt returns to 0 on the next cycle.
REQ-017 div_cnt holds its value while play=0.
REQ-018 FSM states: IDLE, WAIT_TICK, FETCH, CAPTURE.
REQ-019 IDLE -> WAIT_TICK when play=1; any state except CAPTURE -> IDLE when play=0 (div_cnt, Add and pending sample are kept).
REQ-020 WAIT_TICK -> FETCH on tick; FETCH -> CAPTURE unconditionally; CAPTURE -> WAIT_TICK unconditionally.
REQ-021 Add stays stable from WAIT_TICK through CAPTURE; the ROM output present in CAPTURE belongs to Add.
REQ-022 In CAPTURE: sample_out <= music_content; sample_valid <= 1; Add advances (REQ-024).
REQ-023 Latency: tick in cycle T puts sample_valid=1 with the new data in cycle T+3.
REQ-024 Add advances by 1 in CAPTURE; at LAST_ADDR it follows REQ-033/034; Add never exceeds LAST_ADDR.
REQ-025 Handshake: sample_valid stays 1 and sample_out stays stable until a cycle with sample_valid=1 and sample_ready=1; sample_valid clears in the next cycle unless CAPTURE reloads it in that same cycle.
REQ-026 If a tick occurs while sample_valid=1 and not accepted in that cycle, overrun <= 1; the fetch proceeds and the new sample overwrites the pending one.
REQ-027 restart: Add <= 0, div_cnt <= 0, sample_valid <= 0, next state = WAIT_TICK if play=1 else IDLE; overrun is unchanged.
REQ-028 restart takes priority over tick, CAPTURE advance and handshake in the same cycle.
REQ-029 overrun clears only on reset or restart while play=0.

Reset
REQ-030 Reset_n=0 forces asynchronously: state IDLE, Add=0, div_cnt=0, sample_out=0, sample_valid=0, overrun=0, playing=0.
REQ-031 Reset asserted mid-FETCH or mid-CAPTURE discards the in-flight sample; no partial update is visible after release.
REQ-032 After release, the first tick occurs DIV cycles after play is first sampled 1.

Configuration
REQ-033 Macro MUSIC_LOOP_EN defined: CAPTURE at LAST_ADDR sets Add <= 0, and playback continues seamlessly.
REQ-034 MUSIC_LOOP_EN undefined: CAPTURE at LAST_ADDR keeps Add=LAST_ADDR, delivers that last sample, then enters IDLE and stays there until restart; play alone does not resume.

Verification
REQ-035 DIV=4, play=1, sample_ready=1, ROM mem[a]=a+5 -> sample_out 5,6,7 with valid pulses every 4 cycles, first at cycle 3 after first tick.
REQ-036 sample_ready=0 for 10 cycles with DIV=4 -> overrun=1, sample_out=latest sample, sample_valid held high throughout.
REQ-037 Drop play at Add=10 for 20 cycles, then raise it -> no Add change while paused; next sample is mem[10].
REQ-038 Add reaches 43113 -> next Add=0 with MUSIC_LOOP_EN defined; without it, playing=0, Add=43113, and sample 43113 is delivered once.
REQ-039 restart pulse in the same cycle as CAPTURE at Add=200 -> Add=0, sample_valid=0, no sample 200 delivered.
REQ-040 Reset_n low during FETCH -> all outputs zero immediately, without waiting for a clock edge; after release and play=1, the first sample is mem[0].

Source files
------------

// File: rtl/music_player.sv
// -----------------------------------------------------------------------------
// music_player
//   Streams samples out of a synchronous sample ROM at a fixed sample rate.
//   A divider produces one tick every DIV clocks while play_i is high. Each
//   tick fetches the word at Add_o. The word is captured into sample_out_o and
//   offered downstream with a valid/ready handshake.
//
// Ports
//   Clk_i            sole clock, rising edge
//   Reset_n_i        asynchronous active-low reset
//   play_i           level: 1 = run, 0 = pause (position held)
//   restart_i        single-cycle pulse, rewinds to address 0
//   Add_o            registered ROM address
//   music_content_i  ROM data, valid one clock after Add_o is presented
//   sample_out_o     captured sample toward the audio stage
//   sample_valid_o   sample_out_o holds an unconsumed sample
//   sample_ready_i   downstream accepts sample_out_o this cycle
//   playing_o        high in every state except IDLE
//   overrun_o        sticky: a tick arrived while a sample was still pending
//
// Build option
//   MUSIC_LOOP_EN  defined: playback wraps from LAST_ADDR back to address 0.
//                  undefined: the last sample is delivered, then the player
//                  parks in IDLE until restart_i.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// IDLE      | paused, finished or just reset; divider, address, sample held
// WAIT_TICK | playing, waiting for the sample-rate tick
// FETCH     | Add_o presented to the ROM, data returns next cycle
// CAPTURE   | ROM word latched into sample_out_o, address advanced
// -----------------------------------------------------------------------------
module music_player #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 17,
  parameter int LAST_ADDR = 43113,
  parameter int DIV       = 1250
) (
  input  logic              Clk_i,
  input  logic              Reset_n_i,
  input  logic              play_i,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] Add_o,
  input  logic [DATA_W-1:0] music_content_i,
  output logic [DATA_W-1:0] sample_out_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              playing_o,
  output logic              overrun_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_TICK = 2'd1;
  localparam logic [1:0] S_FETCH     = 2'd2;
  localparam logic [1:0] S_CAPTURE   = 2'd3;

  localparam logic [15:0]       DIV_LAST  = 16'(DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  logic [1:0]        state_q,   state_d;
  logic [15:0]       div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0] add_q,     add_d;
  logic [DATA_W-1:0] sample_q,  sample_d;
  logic              valid_q,   valid_d;
  logic              overrun_q, overrun_d;
  // Set once the final sample has been captured in non-looping builds; it
  // keeps IDLE from being left by play_i alone.
  logic              done_q,    done_d;

  logic tick;
  logic at_last;

  assign tick    = play_i && (div_cnt_q == DIV_LAST);
  assign at_last = (add_q == ADDR_LAST);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    add_d     = add_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    done_d    = done_q;

    // Divider free-runs with play_i, independent of the FSM state.
    if (play_i) begin
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
    end

    if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end

    // Only a tick that actually launches a fetch can clobber a pending sample.
    if ((state_q == S_WAIT_TICK) && tick && valid_q && !sample_ready_i) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (play_i && !done_q) begin
          state_d = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!play_i) begin
          state_d = S_IDLE;
        end else if (tick) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Pausing here drops the fetch; Add_o is unchanged so it is
        // simply re-fetched on the next tick after resume.
        state_d = play_i ? S_CAPTURE : S_IDLE;
      end
      S_CAPTURE: begin
        // CAPTURE always completes, even if play_i just dropped.
        sample_d = music_content_i;
        valid_d  = 1'b1;
        state_d  = S_WAIT_TICK;
        if (at_last) begin
`ifdef MUSIC_LOOP_EN
          add_d = '0;
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          add_d = add_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Restart overrides tick, capture and handshake in the same cycle.
    if (restart_i) begin
      add_d     = '0;
      div_cnt_d = 16'd0;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      overrun_d = play_i ? overrun_q : 1'b0;
      state_d   = play_i ? S_WAIT_TICK : S_IDLE;
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 16'd0;
      add_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      add_q     <= add_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  assign Add_o          = add_q;
  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign playing_o      = (state_q != S_IDLE);
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_music_player.sv
// -----------------------------------------------------------------------------
// tb_music_player
//   Scoreboard bench for music_player with DIV=4 and a shortened ROM
//   (LAST_ADDR=300). ROM model: mem[a] = a + 5, one clock read latency.
//   Stimulus pushes the samples it expects to be accepted; a monitor pops and
//   compares on every valid&ready cycle. Inputs change 1 time unit after the
//   rising edge; the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_music_player;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 17;
  localparam int LAST_ADDR = 300;
  localparam int DIV       = 4;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b1;
  logic              play = 1'b0;
  logic              restart = 1'b0;
  logic              sample_ready = 1'b0;
  logic [ADDR_W-1:0] Add;
  logic [DATA_W-1:0] music_content = '0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              playing;
  logic              overrun;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;

  music_player #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST_ADDR), .DIV(DIV)
  ) dut (
    .Clk_i(Clk),
    .Reset_n_i(Reset_n),
    .play_i(play),
    .restart_i(restart),
    .Add_o(Add),
    .music_content_i(music_content),
    .sample_out_o(sample_out),
    .sample_valid_o(sample_valid),
    .sample_ready_i(sample_ready),
    .playing_o(playing),
    .overrun_o(overrun)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: mem[a] = a + 5
  always @(posedge Clk) music_content <= DATA_W'(Add) + DATA_W'(5);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_range(input int first_a, input int last_a);
    for (int a = first_a; a <= last_a; a++) exp_q.push_back(DATA_W'(a + 5));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d samples still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_add(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (32'(Add) != target && k < budget) begin
      step(1);
      k++;
    end
    check(name, 32'(Add), target);
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (Reset_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_sample: got %0d, required no sample", sample_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sample", 32'(sample_out), 32'(mon_exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    // Reset state
    #1 Reset_n = 1'b0;
    #2;
    check("rst_add", 32'(Add), 0);
    check("rst_sample_out", 32'(sample_out), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_overrun", 32'(overrun), 0);
    step(2);
    Reset_n = 1'b1;
    step(1);

    // Normal playback: 5,6,7 with first valid 6 cycles after play
    push_range(0, 2);
    play = 1'b1;
    sample_ready = 1'b1;
    step(6);
    check("first_valid", 32'(sample_valid), 1);
    check("first_data", 32'(sample_out), 5);
    step(1);
    check("valid_cleared", 32'(sample_valid), 0);
    step(7);
    check("third_valid", 32'(sample_valid), 1);
    check("third_data", 32'(sample_out), 7);
    play = 1'b0;
    step(1);
    check("pause_playing", 32'(playing), 0);
    check("pause_add", 32'(Add), 3);
    check("pause_valid", 32'(sample_valid), 0);

    // Overrun: ready low, samples 8 then 9 overwrite, valid held
    sample_ready = 1'b0;
    play = 1'b1;
    step(4);
    check("ovr_first_data", 32'(sample_out), 8);
    check("ovr_first_valid", 32'(sample_valid), 1);
    check("ovr_not_yet", 32'(overrun), 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (sample_valid !== 1'b1) ok = 1'b0;
    end
    check("ovr_valid_held", 32'(ok), 1);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_latest", 32'(sample_out), 9);
    exp_q.push_back(DATA_W'(9));
    play = 1'b0;
    sample_ready = 1'b1;
    step(1);
    check("ovr_accept_clear", 32'(sample_valid), 0);
    check("ovr_pause_add", 32'(Add), 5);

    // Pause 20 cycles: address must not move, then resume at mem[5]
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (Add !== ADDR_W'(5) || playing !== 1'b0 || sample_valid !== 1'b0) ok = 1'b0;
    end
    check("pause_hold", 32'(ok), 1);
    push_range(5, 199);
    play = 1'b1;

    // Restart in the CAPTURE cycle of address 200
    wait_add("reach_add_200", 200, 2000);
    step(3);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_add", 32'(Add), 0);
    check("restart_valid", 32'(sample_valid), 0);
    check("restart_keeps_overrun", 32'(overrun), 1);
    check("restart_playing", 32'(playing), 1);
    check("restart_queue_empty", 32'(exp_q.size()), 0);

    // Run through the end of the ROM
    push_range(0, LAST_ADDR);
`ifdef MUSIC_LOOP_EN
    push_range(0, 0);
`endif
    wait_drain("end_of_rom", 1500);
`ifdef MUSIC_LOOP_EN
    play = 1'b0;
    step(1);
    check("loop_wrap_add", 32'(Add), 1);
`else
    check("end_playing", 32'(playing), 0);
    check("end_add", 32'(Add), LAST_ADDR);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (playing !== 1'b0 || Add !== ADDR_W'(LAST_ADDR)) ok = 1'b0;
    end
    check("end_parked", 32'(ok), 1);
    play = 1'b0;
    step(1);
`endif

    // Restart while paused clears overrun
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_idle_overrun", 32'(overrun), 0);
    check("restart_idle_add", 32'(Add), 0);
    check("restart_idle_playing", 32'(playing), 0);

    // Asynchronous reset during FETCH of address 1
    push_range(0, 0);
    play = 1'b1;
    sample_ready = 1'b1;
    step(8);
    check("pre_reset_add", 32'(Add), 1);
    check("pre_reset_playing", 32'(playing), 1);
    Reset_n = 1'b0;
    #1;
    check("async_rst_add", 32'(Add), 0);
    check("async_rst_sample_out", 32'(sample_out), 0);
    check("async_rst_valid", 32'(sample_valid), 0);
    check("async_rst_playing", 32'(playing), 0);
    check("async_rst_overrun", 32'(overrun), 0);
    step(2);
    Reset_n = 1'b1;
    push_range(0, 0);
    wait_drain("post_reset_first", 60);
    play = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
